// File: rtl/phy_rx_sync_ctrl_if.sv
// Interface between the receive sync controller and its neighbours.
// It carries the serial line, the resync request and the scheduled byte stream.
interface phy_rx_sync_ctrl_if;
  logic       serial_in;
  logic       resync;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic [1:0] lane_sel;
  logic       active;
  logic [1:0] sync_state;

  modport master (
    output serial_in, resync,
    input  byte_out, byte_valid, lane_sel, active, sync_state
  );

  modport slave (
    input  serial_in, resync,
    output byte_out, byte_valid, lane_sel, active, sync_state
  );
endinterface

// File: rtl/phy_rx_sync_ctrl.sv
// Receive-side sync controller: comma-based byte alignment, lock detection
// and round-robin lane tagging of data bytes for the unstriper.
module phy_rx_sync_ctrl #(
  parameter logic [7:0]  COMMA      = 8'hBC,
  parameter logic [7:0]  IDLE       = 8'h7C,
  parameter int unsigned SYNC_COUNT = 4,
  parameter int unsigned NUM_LANES  = 4
) (
  input  logic                 clk_32f,
  input  logic                 reset_L,
  phy_rx_sync_ctrl_if.slave    rx
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    LOCKED = 2'd2
  } sync_state_e;

  localparam logic [1:0] LANE_MASK = 2'(NUM_LANES - 1);
  localparam logic [3:0] SYNC_LAST = 4'(SYNC_COUNT);

  sync_state_e state_q, state_d;
  logic [7:0]  shreg_q, shreg_nx;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [3:0]  bc_cnt_q, bc_cnt_d;
  logic [1:0]  lane_ptr_q, lane_ptr_d;
  logic [7:0]  byte_out_q, byte_out_d;
  logic        byte_valid_q, byte_valid_d;
  logic [1:0]  lane_sel_q, lane_sel_d;
  logic        active_q, active_d;
  logic        boundary;

  assign shreg_nx = {shreg_q[6:0], rx.serial_in};
  assign boundary = (bit_cnt_q == 3'd7);

  // NOTE: every variable gets a default before the case so no path leaves
  // it unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q + 3'd1;
    bc_cnt_d     = bc_cnt_q;
    lane_ptr_d   = lane_ptr_q;
    byte_out_d   = byte_out_q;
    lane_sel_d   = lane_sel_q;
    byte_valid_d = 1'b0;
    active_d     = active_q;

    if (rx.resync) begin
      // Resync overrides any boundary on the same edge, so a byte in flight is dropped.
      state_d    = SEARCH;
      bit_cnt_d  = 3'd0;
      bc_cnt_d   = 4'd0;
      lane_ptr_d = 2'd0;
      active_d   = 1'b0;
    end else begin
      case (state_q)
        SEARCH: begin
          if (shreg_nx == COMMA) begin
            bit_cnt_d = 3'd0;
            bc_cnt_d  = 4'd1;
            state_d   = ALIGN;
          end
        end
        ALIGN: begin
          if (boundary) begin
            if (shreg_nx == COMMA) begin
              bc_cnt_d = bc_cnt_q + 4'd1;
              if (bc_cnt_q + 4'd1 == SYNC_LAST) begin
                state_d    = LOCKED;
                active_d   = 1'b1;
                lane_ptr_d = 2'd0;
              end
            end else begin
              bc_cnt_d = 4'd0;
              state_d  = SEARCH;
            end
          end
        end
        LOCKED: begin
          if (boundary) begin
            if (shreg_nx == COMMA) begin
              lane_ptr_d = 2'd0;
            end else if (shreg_nx != IDLE) begin
              byte_out_d   = shreg_nx;
              lane_sel_d   = lane_ptr_q;
              byte_valid_d = 1'b1;
              lane_ptr_d   = (lane_ptr_q + 2'd1) & LANE_MASK;
            end
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk_32f) begin
    if (!reset_L) begin
      state_q      <= SEARCH;
      shreg_q      <= 8'd0;
      bit_cnt_q    <= 3'd0;
      bc_cnt_q     <= 4'd0;
      lane_ptr_q   <= 2'd0;
      byte_out_q   <= 8'd0;
      byte_valid_q <= 1'b0;
      lane_sel_q   <= 2'd0;
      active_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_nx;
      bit_cnt_q    <= bit_cnt_d;
      bc_cnt_q     <= bc_cnt_d;
      lane_ptr_q   <= lane_ptr_d;
      byte_out_q   <= byte_out_d;
      byte_valid_q <= byte_valid_d;
      lane_sel_q   <= lane_sel_d;
      active_q     <= active_d;
    end
  end

  assign rx.byte_out   = byte_out_q;
  assign rx.byte_valid = byte_valid_q;
  assign rx.lane_sel   = lane_sel_q;
  assign rx.active     = active_q;
  assign rx.sync_state = state_q;

endmodule
